// File: rtl/mdu_iterative.sv
// RV32M multiply/divide unit: one bit per cycle, shift-add multiply, restoring divide.
// Optional MDU_FAST_EN: special cases (B==0, signed overflow, zero multiply operand) skip straight to DONE.
module mdu_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] S
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            r_state;
    logic [2:0]        r_op;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_b_zero;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_s;

    logic              w_signed_a;
    logic              w_signed_b;
    logic              w_sign_a;
    logic              w_sign_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_trial;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;

    // Signed operands: A for MUL/MULH/MULHSU/DIV/REM, B for MUL/MULH/DIV/REM.
    assign w_signed_a = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign w_signed_b = w_signed_a && (funct3 != 3'b010);
    assign w_sign_a   = w_signed_a & A[XLEN-1];
    assign w_sign_b   = w_signed_b & B[XLEN-1];
    assign w_mag_a    = w_sign_a ? -A : A;
    assign w_mag_b    = w_sign_b ? -B : B;

    // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opnd};
    assign w_div_next  = w_div_trial[XLEN] ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                           : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quo  = ((r_sign_a ^ r_sign_b) && !r_b_zero) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_result = '0;
        case (r_op)
            3'b000:                 w_result = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_result = w_quo;
            default:                w_result = w_rem;
        endcase
    end

`ifdef MDU_FAST_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    always_comb begin
        w_fast     = 1'b0;
        w_fast_res = '0;
        if (!funct3[2]) begin
            w_fast = (A == '0) || (B == '0);
        end else if (B == '0) begin
            w_fast     = 1'b1;
            w_fast_res = funct3[1] ? A : '1;
        end else if (!funct3[0] && (A == MIN_NEG) && (B == '1)) begin
            w_fast     = 1'b1;
            w_fast_res = funct3[1] ? '0 : MIN_NEG;
        end
    end
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_s      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op     <= funct3;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_b_zero <= (B == '0);
                        r_cnt    <= '0;
                        if (funct3[2]) begin
                            r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                            r_opnd <= w_mag_b;
                        end else begin
                            r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                            r_opnd <= w_mag_a;
                        end
                        if (w_fast) begin
                            r_s     <= w_fast_res;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc <= r_op[2] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN - 1)) r_state <= FIX;
                end
                FIX: begin
                    r_s     <= w_result;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign S    = r_s;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed RV32M cases, randomized ops against
// a plain-arithmetic reference model, ignored-start and mid-operation reset scenarios.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] S;

    int errors = 0;
    int checks = 0;

    mdu_iterative #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .S      (S)
    );

    always #5 clk = ~clk;

    // Reference model: RV32M results straight from signed/unsigned 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(int'(a) / int'(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(int'(a) % int'(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int expected_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_FAST_EN
        if (b == 0) return 1;
        if (!f[2] && a == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`else
        if (f == 3'd7 && a == 32'hDEAD_BEEF && b == 32'hDEAD_BEEF) return 34;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One full operation starting in the current cycle; scrambles inputs while busy.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_s);
        int lat;
        int busy_cnt;
        int want_lat;
        want_lat = expected_latency(f, a, b);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b, want 0/0", name, busy, done);
        end
        start = 1'b1; funct3 = f; A = a; B = b;
        @(negedge clk);
        lat = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            start  = 1'($urandom_range(0, 1));
            funct3 = 3'($urandom);
            A      = $urandom;
            B      = $urandom;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat >= 100) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, lat);
            return;
        end
        if (lat != want_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
        end
        checks++;
        if (S !== exp_s) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, S, exp_s);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
        checks++;
        if (busy_cnt != want_lat - 1) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, want_lat - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; funct3 = 3'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || S !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b S=%h, want 0/0/00000000", busy, done, S);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op("mul_7x6",      3'd0, 32'd7,        32'd6,        32'h0000_002A);
        run_op("mulh_m1x2",    3'd1, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFF);
        run_op("mulhu_m1x2",   3'd3, 32'hFFFF_FFFF, 32'd2,       32'h0000_0001);
        run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD);
        run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF);
        run_op("divu_100_7",   3'd5, 32'd100,      32'd7,        32'd14);
        run_op("remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2);
    endtask

    task automatic test_special();
        run_op("divu_by0",     3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF);
        run_op("rem_by0",      3'd6, 32'd5,        32'd0,        32'd5);
        run_op("div_by0_neg",  3'd4, 32'hFFFF_FFF9, 32'd0,       32'hFFFF_FFFF);
        run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("mul_zero",     3'd1, 32'd0,        32'h1234_5678, 32'd0);
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, model(f, a, b));
        end
    endtask

    // Second start while busy and operand changes mid-op must not disturb the result.
    task automatic test_start_ignored();
        int n_done;
        int at;
        logic [31:0] s_at;
        n_done = 0; at = -1; s_at = 32'd0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; A = 32'd3; B = 32'd3;
        @(negedge clk);
        for (int c = 1; c <= 80; c++) begin
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin at = c; s_at = S; end
            end
            start = (c == 5);
            if (c == 5) begin A = 32'd9; B = 32'd9; end
            if (c == 10) A = 32'h0000_1234;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d want 1", n_done);
        end
        checks++;
        if (at != 34) begin
            errors++;
            $display("FAIL ignore_done_cycle: got %0d want 34", at);
        end
        checks++;
        if (s_at !== 32'd9) begin
            errors++;
            $display("FAIL ignore_result: got %h want 00000009", s_at);
        end
    endtask

    task automatic test_reset_mid();
        int n_done;
        n_done = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 20) rst = 1'b1;
            if (c == 21) begin
                rst = 1'b0;
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || S !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_mid_state: busy=%b done=%b S=%h, want 0/0/00000000", busy, done, S);
                end
            end
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d done pulses want 0", n_done);
        end
        run_op("after_reset", 3'd0, 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFF6);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_mulhu",  3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("b2b_remu",   3'd7, 32'hFFFF_FFFF, 32'd10,        32'd5);
        run_op("b2b_div",    3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("b2b_rem",    3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_back_to_back();
        test_random();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
